// File: rtl/conn_box_cfg_if.sv
// Connection-box bus: track/logic-block datapath plus serial configuration port.
// Latency: n/a (signal bundle only).
// Backpressure: cfg_ready qualifies cfg_valid; datapath signals have no flow control.
interface conn_box_cfg_if #(
    parameter int TRACKS    = 5,
    parameter int NUM_LB    = 2,
    parameter int LB_INPUTS = 4
);
    logic [TRACKS-1:0]           track_in;
    logic [TRACKS-1:0]           track_out;
    logic [TRACKS-1:0]           track_oe;
    logic [NUM_LB-1:0]           lb_out;
    logic [NUM_LB*LB_INPUTS-1:0] lb_in;
    logic                        cfg_start;
    logic                        cfg_valid;
    logic                        cfg_bit;
    logic                        cfg_ready;
    logic                        cfg_busy;
    logic                        cfg_done;
    logic                        cfg_err;

    modport master (
        output track_in, lb_out, cfg_start, cfg_valid, cfg_bit,
        input  track_out, track_oe, lb_in, cfg_ready, cfg_busy, cfg_done, cfg_err
    );

    modport slave (
        input  track_in, lb_out, cfg_start, cfg_valid, cfg_bit,
        output track_out, track_oe, lb_in, cfg_ready, cfg_busy, cfg_done, cfg_err
    );
endinterface

// File: rtl/conn_box_cfg.sv
// Connection box: mux tracks onto logic-block inputs and drive tracks from lb outputs.
// Latency: datapath 0 cycles (REG_OUT=0) or 1 cycle (REG_OUT=1); commit 2 cycles after parity beat.
// Backpressure: cfg_ready high only in SHIFT/PAR; bits offered at other times are dropped.
module conn_box_cfg #(
    parameter int TRACKS    = 5,
    parameter int NUM_LB    = 2,
    parameter int LB_INPUTS = 4,
    parameter int REG_OUT   = 0
) (
    input logic          clk,
    input logic          reset,
    conn_box_cfg_if.slave bus
);
    localparam int SEL_W    = $clog2(TRACKS + 1);
    localparam int DRV_W    = $clog2(NUM_LB + 1);
    localparam int NUM_IN   = NUM_LB * LB_INPUTS;
    localparam int DRV_BASE = NUM_IN * SEL_W;
    localparam int CFG_BITS = DRV_BASE + TRACKS * DRV_W;
    localparam int CNT_W    = $clog2(CFG_BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PAR, CHECK} state_t;

    state_t              state;
    logic [CFG_BITS-1:0] shadow;
    logic [CFG_BITS-1:0] active;
    logic [CNT_W-1:0]    cnt;
    logic                par;
    logic                ready;
    logic                busy;
    logic                done;
    logic                err;
    logic                range_ok;

    logic [NUM_IN-1:0]   lb_in_c;
    logic [TRACKS-1:0]   track_out_c;
    logic [TRACKS-1:0]   track_oe_c;

    // Field range check on the staged image; only meaningful during CHECK.
    always_comb begin
        range_ok = 1'b1;
        for (int j = 0; j < NUM_IN; j++)
            if (shadow[j*SEL_W +: SEL_W] > SEL_W'(TRACKS))
                range_ok = 1'b0;
        for (int t = 0; t < TRACKS; t++)
            if (shadow[DRV_BASE + t*DRV_W +: DRV_W] > DRV_W'(NUM_LB))
                range_ok = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            shadow <= '0;
            active <= '0;
            cnt    <= '0;
            par    <= 1'b0;
            ready  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            // A start outside CHECK (re)opens the load and discards any bit offered with it.
            if (bus.cfg_start && state != CHECK) begin
                state  <= SHIFT;
                shadow <= '0;
                cnt    <= '0;
                par    <= 1'b0;
                err    <= 1'b0;
                ready  <= 1'b1;
                busy   <= 1'b1;
            end else begin
                case (state)
                    SHIFT: if (bus.cfg_valid) begin
                        shadow[cnt] <= bus.cfg_bit;
                        cnt         <= cnt + 1'b1;
                        par         <= par ^ bus.cfg_bit;
                        if (cnt == CNT_W'(CFG_BITS - 1))
                            state <= PAR;
                    end
                    PAR: if (bus.cfg_valid) begin
                        par   <= par ^ bus.cfg_bit;
                        ready <= 1'b0;
                        state <= CHECK;
                    end
                    CHECK: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!par && range_ok) begin
                            active <= shadow;
                            done   <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.cfg_ready = ready;
    assign bus.cfg_busy  = busy;
    assign bus.cfg_done  = done;
    assign bus.cfg_err   = err;

    // Each output is a one-hot compare against the active selector, so a track is never double-driven.
    always_comb begin
        lb_in_c     = '0;
        track_out_c = '0;
        track_oe_c  = '0;
        for (int j = 0; j < NUM_IN; j++)
            for (int k = 1; k <= TRACKS; k++)
                if (active[j*SEL_W +: SEL_W] == SEL_W'(k))
                    lb_in_c[j] = bus.track_in[k-1];
        for (int t = 0; t < TRACKS; t++)
            for (int k = 1; k <= NUM_LB; k++)
                if (active[DRV_BASE + t*DRV_W +: DRV_W] == DRV_W'(k)) begin
                    track_oe_c[t]  = 1'b1;
                    track_out_c[t] = bus.lb_out[k-1];
                end
    end

    if (REG_OUT != 0) begin : g_reg
        always_ff @(posedge clk) begin
            if (reset) begin
                bus.lb_in     <= '0;
                bus.track_out <= '0;
                bus.track_oe  <= '0;
            end else begin
                bus.lb_in     <= lb_in_c;
                bus.track_out <= track_out_c;
                bus.track_oe  <= track_oe_c;
            end
        end
    end else begin : g_comb
        assign bus.lb_in     = lb_in_c;
        assign bus.track_out = track_out_c;
        assign bus.track_oe  = track_oe_c;
    end
endmodule
